counter_sequencer: RTL and testbench

- Controller for the team's loadable up/down counter (inputs d/load/up_down, active-low clear, output q; counts every clock unless loaded).
- Accepts a command {start value, end value, direction, auto-reload} over a valid/ready handshake.
- Loads the counter, lets it run to the end value, then holds it and pulses done.
- Holds the counter by reloading its own output, since the counter has no enable.

---
 rtl/counter_seq_pkg.sv | 21 ++
 rtl/counter_sequencer.sv | 89 ++++++++
 tb/tb_counter_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types for counter_sequencer: state encoding, command record, default width.
package counter_seq_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  // Fields named *_val because "end" is a keyword.
  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] start_val;
    logic [DATA_WIDTH_DEF-1:0] end_val;
    logic                      up;
    logic                      reload;
  } cmd_t;

endpackage

// File: rtl/counter_sequencer.sv
// Drives a loadable up/down counter from start to end value per accepted command.
// Optional run pause input enabled by defining COUNTER_SEQUENCER_PAUSE_EN.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_start,
  input  logic [DATA_WIDTH-1:0] cmd_end,
  input  logic                  cmd_up,
  input  logic                  cmd_reload,
  input  logic                  abort,
`ifdef COUNTER_SEQUENCER_PAUSE_EN
  input  logic                  pause,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] cnt_d,
  output logic                  cnt_load,
  output logic                  cnt_up_down,
  output logic                  cnt_clear_n,
  input  logic [DATA_WIDTH-1:0] cnt_q
);

  seq_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_s_start;
  logic [DATA_WIDTH-1:0] r_s_end;
  logic                  r_s_up;
  logic                  r_s_reload;

  logic w_at_end;
  logic w_pause;

  assign w_at_end = (cnt_q == r_s_end);
`ifdef COUNTER_SEQUENCER_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state    <= IDLE;
      r_s_start  <= '0;
      r_s_end    <= '0;
      r_s_up     <= 1'b0;
      r_s_reload <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_s_start  <= cmd_start;
          r_s_end    <= cmd_end;
          r_s_up     <= cmd_up;
          r_s_reload <= cmd_reload;
          r_state    <= LOAD;
        end
        LOAD: r_state <= abort ? IDLE : RUN;
        // abort outranks the end compare; pause only stalls before the end
        RUN: begin
          if (abort)         r_state <= IDLE;
          else if (w_at_end) r_state <= DONE;
        end
        DONE: r_state <= (!abort && r_s_reload) ? LOAD : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The counter has no enable, so "hold" means reloading its own output.
  always_comb begin
    cmd_ready   = ~clear & (r_state == IDLE);
    busy        = ~clear & (r_state != IDLE);
    done        = ~clear & (r_state == DONE);
    cnt_clear_n = ~clear;
    cnt_up_down = r_s_up;
    cnt_load    = 1'b1;
    cnt_d       = cnt_q;
    case (r_state)
      LOAD: if (!abort) cnt_d = r_s_start;
      RUN:  if (!abort && !w_at_end && !w_pause) cnt_load = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Table-driven bench for counter_sequencer with a behavioural loadable up/down counter.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clear, cmd_valid, cmd_up, cmd_reload, abort;
  logic [W-1:0] cmd_start, cmd_end;
  logic         cmd_ready, busy, done, cnt_load, cnt_up_down, cnt_clear_n;
  logic [W-1:0] cnt_d, cnt_q;
`ifdef COUNTER_SEQUENCER_PAUSE_EN
  logic         pause = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.DATA_WIDTH(W)) dut (
    .clk(clk), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_up(cmd_up), .cmd_reload(cmd_reload),
    .abort(abort),
`ifdef COUNTER_SEQUENCER_PAUSE_EN
    .pause(pause),
`endif
    .busy(busy), .done(done),
    .cnt_d(cnt_d), .cnt_load(cnt_load), .cnt_up_down(cnt_up_down),
    .cnt_clear_n(cnt_clear_n), .cnt_q(cnt_q)
  );

  // The team's counter: synchronous active-low clear, load over count.
  always_ff @(posedge clk) begin
    if (!cnt_clear_n)  cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_d;
    else if (cnt_up_down) cnt_q <= cnt_q + 1'b1;
    else cnt_q <= cnt_q - 1'b1;
  end

  typedef struct {
    logic         valid;
    cmd_t         cmd;
    logic         abort;
    logic [W-1:0] exp_q;
    logic         exp_busy;
    logic         exp_done;
    logic         exp_ready;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic v, logic [W-1:0] s, logic [W-1:0] e, logic up, logic rl,
                              logic ab, logic [W-1:0] q, logic b, logic d, logic r);
    vec_t t;
    t.valid = v; t.cmd.start_val = s; t.cmd.end_val = e; t.cmd.up = up; t.cmd.reload = rl;
    t.abort = ab; t.exp_q = q; t.exp_busy = b; t.exp_done = d; t.exp_ready = r;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic v, cmd_t c, logic ab);
    cmd_valid = v; cmd_start = c.start_val; cmd_end = c.end_val;
    cmd_up = c.up; cmd_reload = c.reload; abort = ab;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_start = '0; cmd_end = '0; cmd_up = 0; cmd_reload = 0; abort = 0;
  endtask

  initial begin
    cmd_t c;
    int   hit;
    clear = 1'b1;
    idle_inputs();

    // Reset state
    @(negedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_clear_n", cnt_clear_n, 0);
    @(negedge clk); clear = 1'b0; #1;
    check("rst_q", cnt_q, 8'h00);
    check("rst_ready_after", cmd_ready, 1);
    check("idle_hold_load", cnt_load, 1);
    check("idle_hold_d", cnt_d, cnt_q);

    // valid, start, end, up, reload, abort | q, busy, done, ready
    // up run 10->14, stray command while busy is ignored
    tv.push_back(mk(1, 8'h10, 8'h14, 1, 0, 0, 8'h00, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h10, 1, 0, 0));
    tv.push_back(mk(1, 8'hAA, 8'hBB, 0, 0, 0, 8'h11, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h12, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h13, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h14, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h14, 1, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h14, 0, 0, 1));
    // down wrap 01->FE
    tv.push_back(mk(1, 8'h01, 8'hFE, 0, 0, 0, 8'h14, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h14, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h01, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'hFF, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'hFE, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'hFE, 1, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'hFE, 0, 0, 1));
    // start == end
    tv.push_back(mk(1, 8'h33, 8'h33, 1, 0, 0, 8'hFE, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'hFE, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h33, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h33, 1, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h33, 0, 0, 1));
    // up wrap FE->01
    tv.push_back(mk(1, 8'hFE, 8'h01, 1, 0, 0, 8'h33, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h33, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'hFE, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'hFF, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h01, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h01, 1, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h01, 0, 0, 1));
    // auto-reload 00->02: done at T+5, T+10; abort at T+11 (LOAD) freezes q
    tv.push_back(mk(1, 8'h00, 8'h02, 1, 1, 0, 8'h01, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h01, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h01, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h02, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h02, 1, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h02, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h01, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h02, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h02, 1, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 8'h02, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h02, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h02, 0, 0, 1));
    // abort on the end-value cycle beats completion
    tv.push_back(mk(1, 8'h05, 8'h07, 1, 0, 0, 8'h02, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h02, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h05, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h06, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 8'h07, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h07, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 8'h07, 0, 0, 1));
    // abort in DONE beats reload
    tv.push_back(mk(1, 8'h20, 8'h20, 0, 1, 0, 8'h07, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h07, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h20, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 8'h20, 1, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h20, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'h20, 0, 0, 1));

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].valid, tv[i].cmd, tv[i].abort);
      #1;
      check($sformatf("v%0d_q", i), cnt_q, tv[i].exp_q);
      check($sformatf("v%0d_busy", i), busy, tv[i].exp_busy);
      check($sformatf("v%0d_done", i), done, tv[i].exp_done);
      check($sformatf("v%0d_ready", i), cmd_ready, tv[i].exp_ready);
    end

    // Clear mid-RUN at q=0x12
    @(negedge clk);
    c.start_val = 8'h10; c.end_val = 8'h14; c.up = 1; c.reload = 0;
    drive(1, c, 0);
    @(negedge clk); idle_inputs();
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk); #1;
      if (cnt_q == 8'h12) hit = 1;
    end
    check("midrst_reached", hit, 1);
    clear = 1'b1; #1;
    check("midrst_clear_n", cnt_clear_n, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", cmd_ready, 0);
    @(negedge clk); clear = 1'b0; #1;
    check("midrst_q", cnt_q, 8'h00);
    check("midrst_ready_after", cmd_ready, 1);
    check("midrst_busy_after", busy, 0);
    hit = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (done || cnt_q != 8'h00) hit = 1;
    end
    check("midrst_quiet", hit, 0);

`ifdef COUNTER_SEQUENCER_PAUSE_EN
    // Pause 3 cycles at 0x11: done moves from T+7 to T+10
    begin
      int paused, done_at, rdy_seen;
      paused = 0; done_at = -1; rdy_seen = 0;
      @(negedge clk);
      c.start_val = 8'h10; c.end_val = 8'h14; c.up = 1; c.reload = 0;
      drive(1, c, 0);
      for (int k = 1; k < 20; k++) begin
        @(negedge clk);
        cmd_valid = (k == 4);
        cmd_start = 8'h55; cmd_end = 8'h66;
        #1;
        if (cmd_valid && cmd_ready) rdy_seen = 1;
        pause = (cnt_q == 8'h11 && paused < 3);
        if (pause) paused++;
        if (done && done_at < 0) done_at = k;
      end
      pause = 0; idle_inputs();
      check("pause_done_at", done_at, 10);
      check("pause_no_accept", rdy_seen, 0);
      check("pause_final_q", cnt_q, 8'h14);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
